// File: rtl/rock_pkg.sv
// Shared types and helpers for the DSP cry-volume transmit path.
// Used by dsp_volume_tx and vol_window_acc.
package rock_pkg;

  localparam int VOL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } dsp_tx_state_t;

  function automatic logic [VOL_W-1:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[VOL_W-1:0];
  endfunction

endpackage

// File: rtl/vol_window_acc.sv
// Windowed |sample| reduction (mean, or peak when VOL_PEAK_EN is defined),
// emitting a one-cycle done flag with the scaled, saturated 8-bit volume.
module vol_window_acc
  import rock_pkg::*;
#(
  parameter int SAMPLE_W  = 12,
  parameter int WIN_LOG2  = 8,
  parameter int GAIN_LOG2 = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       done,
  output logic [VOL_W-1:0]           vol
);

  logic [SAMPLE_W-1:0] mag_p0;
  logic [WIN_LOG2-1:0] cnt;
  logic                last_p0;
  logic [31:0]         scaled_p0;

  // Negating the most negative code yields the same bit pattern, read as 2**(SAMPLE_W-1).
  assign mag_p0  = sample[SAMPLE_W-1] ? $unsigned(-sample) : $unsigned(sample);
  assign last_p0 = sample_valid && (cnt == '1);

`ifdef VOL_PEAK_EN
  logic [SAMPLE_W-1:0] peak, peak_nxt;

  assign peak_nxt  = (mag_p0 > peak) ? mag_p0 : peak;
  assign scaled_p0 = (32'(peak_nxt) << GAIN_LOG2) >> (SAMPLE_W - 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak <= '0;
    end else if (sample_valid) begin
      peak <= last_p0 ? '0 : peak_nxt;
    end
  end
`else
  localparam int ACC_W = SAMPLE_W + WIN_LOG2;

  logic [ACC_W-1:0] sum, sum_nxt;

  assign sum_nxt   = sum + ACC_W'(mag_p0);
  assign scaled_p0 = (32'(sum_nxt >> WIN_LOG2) << GAIN_LOG2) >> (SAMPLE_W - 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (sample_valid) begin
      sum <= last_p0 ? '0 : sum_nxt;
    end
  end
`endif

  // Count wraps to zero exactly at the window boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (sample_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = last_p0;
  assign vol  = sat8(scaled_p0);

endmodule

// File: rtl/dsp_volume_tx.sv
// DSP-side transmitter of the cry-volume link: window reduction, 1-deep pending
// register and the DSPready hold/gap strobe FSM. Optional build macro: VOL_PEAK_EN.
module dsp_volume_tx
  import rock_pkg::*;
#(
  parameter int SAMPLE_W  = 12,
  parameter int WIN_LOG2  = 8,
  parameter int GAIN_LOG2 = 0,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [7:0]                 DSPingang,
  output logic                       DSPready,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic               win_done_p0;
  logic [VOL_W-1:0]   win_vol_p0;
  logic [VOL_W-1:0]   pend_p1;
  logic               vld_p1;
  logic               take;
  dsp_tx_state_t      state;
  logic [CNT_W-1:0]   cnt;

  vol_window_acc #(
    .SAMPLE_W (SAMPLE_W),
    .WIN_LOG2 (WIN_LOG2),
    .GAIN_LOG2(GAIN_LOG2)
  ) u_acc (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .done        (win_done_p0),
    .vol         (win_vol_p0)
  );

  assign take = (state == IDLE) && vld_p1;

  // Stage p0 -> p1: pending register; a write that finds it full and not being taken drops a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_p1 <= '0;
      vld_p1  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (win_done_p0) begin
        pend_p1 <= win_vol_p0;
        vld_p1  <= 1'b1;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end
      if (win_done_p0 && vld_p1 && !take) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Stage p1 -> link: strobe FSM, cnt counts remaining cycles of SEND or GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      DSPingang <= '0;
      DSPready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            DSPingang <= pend_p1;
            DSPready  <= 1'b1;
            cnt       <= CNT_W'(HOLD_CYC - 1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (cnt == '0) begin
            DSPready <= 1'b0;
            cnt      <= CNT_W'(GAP_CYC - 1);
            state    <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          DSPready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_volume_tx.sv
// Directed bench for dsp_volume_tx: table of 4-sample windows applied to two
// instances (gain 0 and gain 3), plus reset-abort and overrun sequences.
module tb_dsp_volume_tx;

  logic              clk;
  logic              reset;
  logic              sv, sv2, clr2;
  logic signed [11:0] smp, smp2;
  logic [7:0]        vol0, vol1, vol2;
  logic              rdy0, rdy1, rdy2;
  logic              ovr0, ovr1, ovr2;

  int ncmp;
  int nerr;

  dsp_volume_tx #(.SAMPLE_W(12), .WIN_LOG2(2), .GAIN_LOG2(0), .HOLD_CYC(4), .GAP_CYC(2)) u0 (
    .clk(clk), .reset(reset), .sample_valid(sv), .sample(smp),
    .DSPingang(vol0), .DSPready(rdy0), .overrun(ovr0), .overrun_clr(1'b0)
  );

  dsp_volume_tx #(.SAMPLE_W(12), .WIN_LOG2(2), .GAIN_LOG2(3), .HOLD_CYC(4), .GAP_CYC(2)) u1 (
    .clk(clk), .reset(reset), .sample_valid(sv), .sample(smp),
    .DSPingang(vol1), .DSPready(rdy1), .overrun(ovr1), .overrun_clr(1'b0)
  );

  dsp_volume_tx #(.SAMPLE_W(12), .WIN_LOG2(1), .GAIN_LOG2(0), .HOLD_CYC(4), .GAP_CYC(2)) u2 (
    .clk(clk), .reset(reset), .sample_valid(sv2), .sample(smp2),
    .DSPingang(vol2), .DSPready(rdy2), .overrun(ovr2), .overrun_clr(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][11:0] s;
    logic             gap;
    logic [7:0]       e0;
    logic [7:0]       e1;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input int a, b, c, d, input logic g,
                              input int m0, m1, p0, p1);
    vec_t v;
    v.s[0] = 12'(a);
    v.s[1] = 12'(b);
    v.s[2] = 12'(c);
    v.s[3] = 12'(d);
    v.gap  = g;
`ifdef VOL_PEAK_EN
    v.e0 = 8'(p0);
    v.e1 = 8'(p1);
`else
    v.e0 = 8'(m0);
    v.e1 = 8'(m1);
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] v);
    @(negedge clk);
    sv  = 1'b1;
    smp = v;
  endtask

  // Expects the strobe 2 clocks after the last sample, HOLD_CYC cycles high, word held afterwards.
  task automatic observe(input string nm, input logic [7:0] x0, input logic [7:0] x1);
    int h0, h1;
    @(negedge clk);
    sv = 1'b0;
    chk({nm, " lat0 rdy0"}, 32'(rdy0), 0);
    chk({nm, " lat0 rdy1"}, 32'(rdy1), 0);
    @(negedge clk);
    chk({nm, " rise rdy0"}, 32'(rdy0), 1);
    chk({nm, " rise rdy1"}, 32'(rdy1), 1);
    chk({nm, " vol0"}, 32'(vol0), 32'(x0));
    chk({nm, " vol1"}, 32'(vol1), 32'(x1));
    h0 = 32'(rdy0);
    h1 = 32'(rdy1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!rdy0 && !rdy1) break;
      if (rdy0) h0++;
      if (rdy1) h1++;
    end
    chk({nm, " hold0"}, 32'(h0), 4);
    chk({nm, " hold1"}, 32'(h1), 4);
    repeat (6) @(negedge clk);
    chk({nm, " keep0"}, 32'(vol0), 32'(x0));
    chk({nm, " keep1"}, 32'(vol1), 32'(x1));
  endtask

  initial begin
    int hi;
    logic found;
    ncmp  = 0;
    nerr  = 0;
    reset = 1'b0;
    sv    = 1'b0;
    sv2   = 1'b0;
    clr2  = 1'b0;
    smp   = '0;
    smp2  = '0;

    tbl[0] = mk(100, -100, 100, -100, 1'b0,   6,  50,   6,  50);
    tbl[1] = mk(-2048, -2048, -2048, -2048, 1'b0, 128, 255, 128, 255);
    tbl[2] = mk(0, 0, 0, 0, 1'b0,             0,   0,   0,   0);
    tbl[3] = mk(2047, 2047, 2047, 2047, 1'b0, 127, 255, 127, 255);
    tbl[4] = mk(10, -300, 20, 5, 1'b0,        5,  41,  18, 150);
    tbl[5] = mk(16, -16, 15, -17, 1'b0,       1,   8,   1,   8);
    tbl[6] = mk(1000, -500, 250, -250, 1'b0, 31, 250,  62, 255);
    tbl[7] = mk(100, -100, 100, -100, 1'b1,   6,  50,   6,  50);
    tbl[8] = mk(10, -300, 20, 5, 1'b1,        5,  41,  18, 150);
    tbl[9] = mk(1000, -500, 250, -250, 1'b1, 31, 250,  62, 255);

    // Reset state, sampled while reset is held with sample_valid active.
    sv = 1'b1;
    smp = 12'sd500;
    repeat (3) @(negedge clk);
    chk("rst vol0", 32'(vol0), 0);
    chk("rst rdy0", 32'(rdy0), 0);
    chk("rst ovr0", 32'(ovr0), 0);
    chk("rst vol1", 32'(vol1), 0);
    chk("rst rdy1", 32'(rdy1), 0);
    chk("rst vol2", 32'(vol2), 0);
    chk("rst rdy2", 32'(rdy2), 0);
    chk("rst ovr2", 32'(ovr2), 0);
    sv = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (tbl[i].gap && j > 0) begin
          repeat (2) begin
            @(negedge clk);
            sv = 1'b0;
          end
        end
        push(tbl[i].s[j]);
      end
      observe($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1);
    end
    chk("no ovr0", 32'(ovr0), 0);
    chk("no ovr1", 32'(ovr1), 0);

    // Reset in the middle of SEND with a partial next window already counted.
    push(12'sd100); push(-12'sd100); push(12'sd100); push(-12'sd100);
    push(12'sd2047); push(12'sd2047);
    @(negedge clk);
    sv = 1'b0;
    chk("pre-rst rdy0", 32'(rdy0), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort rdy0", 32'(rdy0), 0);
    chk("abort vol0", 32'(vol0), 0);
    chk("abort rdy1", 32'(rdy1), 0);
    chk("abort vol1", 32'(vol1), 0);
    @(negedge clk);
    reset = 1'b1;
    push(12'sd100); push(-12'sd100);
    @(negedge clk);
    sv = 1'b0;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy0 || rdy1) hi++;
    end
    chk("half window silent", 32'(hi), 0);
    push(12'sd100); push(-12'sd100);
    observe("post-rst", 8'd6, 8'd50);

    // Back-to-back two-sample windows outpace the strobe: overrun, latest word wins.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      sv2  = 1'b1;
      smp2 = (k < 12) ? 12'sd160 : ((k == 12) ? 12'sd800 : -12'sd800);
    end
    @(negedge clk);
    sv2 = 1'b0;
    chk("ovr set", 32'(ovr2), 1);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rdy2 && vol2 == 8'd50) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("latest sent", 32'(found), 1);
    repeat (20) @(negedge clk);
    chk("latest kept", 32'(vol2), 50);
    chk("ovr sticky", 32'(ovr2), 1);
    chk("ovr rdy idle", 32'(rdy2), 0);
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("ovr cleared", 32'(ovr2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
